// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding, sync marker and field widths for the boot loader
package boot_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } boot_state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - pairs payload bytes into little-endian words and drives the imem write port
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              clear,
  input  logic              loLoad,
  input  logic              hiLoad,
  input  logic [BYTE_W-1:0] byteIn,
  output logic              imemWe,
  output logic [LEN_W-1:0]  imemAddr,
  output logic [WORD_W-1:0] imemWdata,
  output logic [LEN_W-1:0]  wordIndex
);

  logic [BYTE_W-1:0] loByte;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      loByte    <= '0;
      imemWe    <= 1'b0;
      imemAddr  <= '0;
      imemWdata <= '0;
      wordIndex <= '0;
    end else begin
      imemWe <= hiLoad;
      if (loLoad) begin
        loByte <= byteIn;
      end
      if (clear) begin
        wordIndex <= '0;
      end else if (hiLoad) begin
        // imem is byte-addressed, so word n lands at byte address 2n
        imemAddr  <= wordIndex << 1;
        imemWdata <= {byteIn, loByte};
        wordIndex <= wordIndex + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader for instruction memory; BOOT_CHECKSUM_EN adds a trailing XOR check byte
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [LEN_W-1:0]  imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IMEM_WORDS);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t ST_AFTER_DATA = ST_CHECK;
`else
  localparam boot_state_t ST_AFTER_DATA = ST_DONE;
`endif

  boot_state_t       state, stateNext;
  logic [LEN_W-1:0]  length;
  logic [LEN_W-1:0]  lenFull;
  logic [LEN_W-1:0]  wordIndex;
  logic              rxReady;
  logic              coreRstN;
  logic              accept;
  logic              syncHit;

  assign accept  = rx_valid && rxReady;
  assign lenFull = {rx_data, length[7:0]};
  // Sync only restarts from IDLE/ERROR; inside a frame 0xA5 is ordinary data
  assign syncHit = accept && (rx_data == SYNC_BYTE) && (state == ST_IDLE || state == ST_ERROR);

  always_comb begin
    stateNext = state;
    if (accept) begin
      case (state)
        ST_IDLE, ST_ERROR: if (syncHit) stateNext = ST_LEN_LO;
        ST_LEN_LO:  stateNext = ST_LEN_HI;
        ST_LEN_HI: begin
          if (lenFull > MAX_LEN)       stateNext = ST_ERROR;
          else if (lenFull == '0)      stateNext = ST_AFTER_DATA;
          else                         stateNext = ST_DATA_LO;
        end
        ST_DATA_LO: stateNext = ST_DATA_HI;
        ST_DATA_HI: stateNext = (wordIndex + 1'b1 < length) ? ST_DATA_LO : ST_AFTER_DATA;
`ifdef BOOT_CHECKSUM_EN
        ST_CHECK:   stateNext = (rx_data == checksum) ? ST_DONE : ST_ERROR;
`endif
        default:    stateNext = state;
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [BYTE_W-1:0] checksum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (syncHit) begin
      checksum <= '0;
    end else if (accept && (state == ST_DATA_LO || state == ST_DATA_HI)) begin
      checksum <= checksum ^ rx_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      length   <= '0;
      rxReady  <= 1'b0;
      coreRstN <= 1'b0;
    end else begin
      state    <= stateNext;
      rxReady  <= (stateNext != ST_DONE);
      // Core leaves reset one cycle after DONE is reached
      coreRstN <= (state == ST_DONE);
      if (accept && state == ST_LEN_LO) length[7:0]  <= rx_data;
      if (accept && state == ST_LEN_HI) length[15:8] <= rx_data;
    end
  end

  boot_word_assembler u_assembler (
    .clk       (clk),
    .rstN      (rst),
    .clear     (syncHit),
    .loLoad    (accept && state == ST_DATA_LO),
    .hiLoad    (accept && state == ST_DATA_HI),
    .byteIn    (rx_data),
    .imemWe    (imem_we),
    .imemAddr  (imem_addr),
    .imemWdata (imem_wdata),
    .wordIndex (wordIndex)
  );

  assign rx_ready   = rxReady;
  assign core_rst_n = coreRstN;
  assign busy       = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA_LO) ||
                      (state == ST_DATA_HI) || (state == ST_CHECK);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader; vectors follow BOOT_CHECKSUM_EN
module tb_imem_boot_loader;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  int  nAssert = 0;
  int  nFail   = 0;
  wr_t expQ[$];

  imem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] outVec();
    return {2'b00, rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, error};
  endfunction

  task automatic pushWr(input logic [15:0] addr, input logic [15:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    expQ.push_back(w);
  endtask

  // monitor: every imem write must match the head of the expected queue
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we) begin
        if (expQ.size() == 0) begin
          check("unexpected_write", {imem_addr, imem_wdata}, 40'h0);
        end else begin
          wr_t w;
          w = expQ.pop_front();
          check("imem_addr", imem_addr, w.addr);
          check("imem_wdata", imem_wdata, w.data);
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int waitCnt = 0;
    @(negedge clk);
    while (!rx_ready && waitCnt < 50) begin
      rx_valid = 1'b0;
      waitCnt++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", rx_ready, 1);
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input byteQ_t f);
    foreach (f[i]) sendByte(f[i]);
  endtask

  task automatic expectDone(input string name);
    idleCycle();
    check({name, "_status"}, {busy, done, error, core_rst_n, rx_ready}, 5'b01000);
    @(negedge clk);
    check({name, "_core_rst_n"}, core_rst_n, 1);
    check({name, "_writes_left"}, expQ.size(), 0);
  endtask

  task automatic expectError(input string name);
    idleCycle();
    check({name, "_status"}, {busy, done, error, core_rst_n, rx_ready}, 5'b00101);
    @(negedge clk);
    check({name, "_core_held"}, core_rst_n, 0);
    check({name, "_writes_left"}, expQ.size(), 0);
  endtask

  task automatic resetPulse(input string name);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    #1;
    check({name, "_reset_outputs"}, outVec(), 40'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic byteQ_t withChk(input byteQ_t f, input logic [7:0] chk);
    byteQ_t r;
    r = f;
`ifdef BOOT_CHECKSUM_EN
    r.push_back(chk);
`else
    if (chk == 8'h00) r = f;
`endif
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail + 1);
    $fatal(1);
  end

  initial begin
    byteQ_t f;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs", outVec(), 40'h0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", rx_ready, 1);
    check("idle_status", {busy, done, error, core_rst_n}, 4'b0000);

    // nominal two-word load, back-to-back bytes
    pushWr(16'h0000, 16'h1234);
    pushWr(16'h0002, 16'hABCD);
    sendFrame(withChk('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB}, 8'h40));
    expectDone("nominal");

`ifdef BOOT_CHECKSUM_EN
    // bad checksum, then recovery by a fresh sync
    resetPulse("badchk");
    pushWr(16'h0000, 16'h1234);
    sendFrame('{8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'h00});
    expectError("badchk");
    pushWr(16'h0000, 16'h1234);
    sendFrame('{8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'h26});
    expectDone("badchk_retry");
`endif

    // length 257 exceeds capacity
    resetPulse("oversize");
    sendFrame('{8'hA5, 8'h01, 8'h01});
    expectError("oversize");

    // length 256 is the largest accepted; cut it short with a reset
    resetPulse("maxlen");
    sendFrame('{8'hA5, 8'h00, 8'h01});
    idleCycle();
    check("maxlen_busy", {busy, error}, 2'b10);

    // leading garbage and rx_valid toggling, zero-length frame
    resetPulse("gaps");
    sendByte(8'h00); idleCycle();
    sendByte(8'hFF); idleCycle();
    check("gaps_ignored", {busy, error}, 2'b00);
    sendByte(8'hA5); idleCycle();
    check("gaps_busy_after_sync", busy, 1);
    f = withChk('{8'h00, 8'h00}, 8'h00);
    foreach (f[i]) begin
      sendByte(f[i]);
      if (i != f.size() - 1) idleCycle();
    end
    expectDone("gaps");

    // reset mid-frame after the first payload byte
    resetPulse("midframe_pre");
    sendFrame('{8'hA5, 8'h01, 8'h00, 8'h34});
    #2;
    check("midframe_busy", busy, 1);
    rst      = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("midframe_reset_outputs", outVec(), 40'h0);
    @(negedge clk);
    rst = 1'b1;
    pushWr(16'h0000, 16'h1234);
    pushWr(16'h0002, 16'hABCD);
    sendFrame(withChk('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB}, 8'h40));
    expectDone("midframe_reload");

    // single word with 0xA5 in the payload treated as data
    resetPulse("single");
    pushWr(16'h0000, 16'h5678);
    sendFrame(withChk('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56}, 8'h2E));
    expectDone("single");

    resetPulse("sync_in_data");
    pushWr(16'h0000, 16'hA5A5);
    sendFrame(withChk('{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5}, 8'h00));
    expectDone("sync_in_data");

    repeat (2) @(negedge clk);
    check("final_writes_left", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the pipelined datapath. Receives a framed byte stream over a valid/ready link and assembles little-endian 16-bit instructions.
- Writes those instructions into the instruction memory, then releases the core from reset.
- Holds the core in reset (core_rst_n=0) until a complete, validated program image has been written.

Parameters:
- IMEM_WORDS, 256, instruction-memory capacity in 16-bit words; the largest accepted length.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader accepts the byte; a transfer occurs when rx_valid && rx_ready at a clk rising edge
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  16  byte address of the write (always even)
- imem_wdata  output  16  instruction word
- core_rst_n  output  1  active-low reset to the datapath; 0 while loading
- busy  output  1  a frame is in progress (states LEN_LO through CHECK)
- done  output  1  image loaded and validated (sticky)
- error  output  1  frame rejected (sticky until the next SYNC_BYTE)

Behaviour:
- Reset is asynchronous and active-low.
  - While rst=0, all outputs are 0: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, error=0.
  - State resets to IDLE; word counter, length and checksum reset to 0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 2*LEN payload bytes (low byte first per word), then a CHK byte.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE, ERROR.
- rx_ready is 1 in every state except DONE, and is registered to 1 on the first cycle after reset release.
- IDLE: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE goes to LEN_LO and clears the counter and checksum.
- LEN_LO: latch length[7:0], go to LEN_HI.
- LEN_HI: latch length[15:8].
  - length > IMEM_WORDS: go to ERROR.
  - length == 0: go to CHECK.
  - Otherwise go to DATA_LO.
- DATA_LO: latch the low byte, go to DATA_HI.
- DATA_HI: on accept, the next cycle drives imem_we=1 with:
  - imem_wdata = {hi, lo}
  - imem_addr = word_index<<1
  - Then word_index increments. imem_we is low on all other cycles.
  - Go to DATA_LO if word_index+1 < length, else go to CHECK.
- Checksum: 8-bit XOR of all payload bytes (length bytes excluded).
- CHECK: on accept, compare CHK with the accumulated checksum. Match goes to DONE; mismatch goes to ERROR.
- DONE: done=1, rx_ready=0. core_rst_n goes to 1 on the cycle after entering DONE (registered). DONE is left only by rst.
- ERROR: error=1, core_rst_n=0, rx_ready=1.
  - Non-sync bytes are discarded.
  - SYNC_BYTE clears error and goes to LEN_LO. It does not clear previously written memory; the new image overwrites it.
- rx_valid=0 in any state: hold state; no timeout.
- A SYNC_BYTE seen mid-frame is treated as data, not as a restart.
- Reset asserted mid-frame: immediate return to IDLE with outputs at reset values. Partial memory contents are left as is.
- Back-to-back bytes (rx_valid held high) are accepted every cycle; throughput is one word per two cycles.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined: CHECK state behaves as above.
- Undefined: the frame has no CHK byte. After the last payload byte (or LEN_HI with length 0) the FSM goes directly to DONE, and the XOR accumulator is not built.

Decomposition:
- Shared package boot_pkg:
  - state enum boot_state_t
  - SYNC_BYTE constant
  - frame field widths (LEN_W=16, BYTE_W=8, WORD_W=16)
- Sub-module boot_word_assembler: byte pairing, word_index counter, registered imem_we/addr/wdata generation. The top level keeps the FSM and the checksum.

Test Plan:
- Nominal load: stream A5 02 00 34 12 CD AB 40 with rx_valid held high.
  - Writes addr 0x0000 = 0x1234, then 0x0002 = 0xABCD.
  - done=1, then core_rst_n=1 one cycle later; rx_ready=0.
- Bad checksum: stream A5 01 00 34 12 00.
  - error=1, core_rst_n stays 0, one write to 0x0000 = 0x1234.
  - Then A5 01 00 34 12 26 gives done=1.
- Oversize length: A5 01 01 (257 > 256).
  - error=1 right after LEN_HI, no imem_we pulses.
- Garbage and gaps: bytes 00 FF A5 00 00 00 with rx_valid toggling every other cycle.
  - Leading bytes are ignored; zero-length frame with CHK=00 gives done=1 and no writes.
- Reset mid-frame: assert rst low after the first payload byte.
  - Outputs go to 0 immediately.
  - After release, a full nominal frame loads correctly.
- BOOT_CHECKSUM_EN undefined: A5 01 00 78 56.
  - Write 0x0000 = 0x5678, done=1 with no trailing byte.
